proc_control_unit: RTL and testbench

- Control FSM for the 16-bit register-transfer processor; sits directly upstream of the bus multiplexer.
- Drives the mux's 10-bit one-hot Select and the register, A, G and ALU load/op strobes.
- Fetches a 9-bit instruction from DIN into an internal IR.
- Sequences mv, mvi, add and sub over a T0..T3 step counter and pulses Done at the end of each instruction.

---
 rtl/proc_control_unit_if.sv | 31 +++
 rtl/proc_control_unit.sv | 111 +++++++++++
 tb/tb_proc_control_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/proc_control_unit_if.sv
// Control-side bundle between the processor control FSM and its datapath.
// CTRL_MVNZ_EN adds the gnz status input used by the mvnz instruction.
interface proc_control_unit_if;
  // run is a level start request, looked at only while the controller sits in T0.
  // It has no ready/ack: done pulsing marks the end of the fetched instruction.
  logic        run;
  logic [15:0] din;
`ifdef CTRL_MVNZ_EN
  logic        gnz;
`endif
  logic [9:0]  select;
  logic [7:0]  rin;
  logic        ain;
  logic        gin;
  logic        addsub;
  logic        done;
  logic [8:0]  ir;
  logic [1:0]  step;

`ifdef CTRL_MVNZ_EN
  modport master (input run, din, gnz,
                  output select, rin, ain, gin, addsub, done, ir, step);
  modport slave  (output run, din, gnz,
                  input select, rin, ain, gin, addsub, done, ir, step);
`else
  modport master (input run, din,
                  output select, rin, ain, gin, addsub, done, ir, step);
  modport slave  (output run, din,
                  input select, rin, ain, gin, addsub, done, ir, step);
`endif
endinterface

// File: rtl/proc_control_unit.sv
// T0..T3 control FSM for the 16-bit register-transfer processor (mv, mvi, add, sub).
// Optional macro CTRL_MVNZ_EN adds the conditional move mvnz (opcode 100) gated by gnz.
module proc_control_unit #(
    parameter logic [9:0] IDLE_SELECT = 10'b00_0000_0000
) (
    input logic clk,
    input logic rst,
    proc_control_unit_if.master bus
);

    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
`ifdef CTRL_MVNZ_EN
    localparam logic [2:0] OP_MVNZ = 3'b100;
`endif
    localparam logic [9:0] SEL_DIN = 10'b10_0000_0000;
    localparam logic [9:0] SEL_G   = 10'b01_0000_0000;

    step_t      step_q, step_d;
    logic [8:0] ir_q;
    logic [2:0] opcode, rx, ry;
    logic       is_alu;
    logic       unused_din;

    assign opcode     = ir_q[8:6];
    assign rx         = ir_q[5:3];
    assign ry         = ir_q[2:0];
    assign is_alu     = (opcode == OP_ADD) || (opcode == OP_SUB);
    assign unused_din = ^bus.din[15:9];
    assign bus.ir     = ir_q;
    assign bus.step   = step_q;

    // Register R_i sits on select bit 7-i.
    function automatic logic [9:0] reg_sel(input logic [2:0] r);
        reg_sel = 10'd1 << (3'd7 - r);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= T0;
            ir_q   <= '0;
        end else begin
            step_q <= step_d;
            if (step_q == T0 && bus.run)
                ir_q <= bus.din[8:0];
        end
    end

    always_comb begin
        step_d = T0;
        case (step_q)
            T0:      step_d = bus.run ? T1 : T0;
            T1:      step_d = is_alu ? T2 : T0;
            T2:      step_d = T3;
            default: step_d = T0;
        endcase
    end

    always_comb begin
        bus.select = IDLE_SELECT;
        bus.rin    = '0;
        bus.ain    = 1'b0;
        bus.gin    = 1'b0;
        bus.addsub = 1'b0;
        bus.done   = 1'b0;
        case (step_q)
            T1: begin
                case (opcode)
                    OP_MV: begin
                        bus.select = reg_sel(ry);
                        bus.rin    = 8'd1 << rx;
                        bus.done   = 1'b1;
                    end
                    OP_MVI: begin
                        bus.select = SEL_DIN;
                        bus.rin    = 8'd1 << rx;
                        bus.done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        bus.select = reg_sel(rx);
                        bus.ain    = 1'b1;
                    end
`ifdef CTRL_MVNZ_EN
                    OP_MVNZ: begin
                        bus.select = reg_sel(ry);
                        bus.rin    = bus.gnz ? (8'd1 << rx) : 8'd0;
                        bus.done   = 1'b1;
                    end
`endif
                    default: bus.done = 1'b1;  // undefined opcode retires as a NOP
                endcase
            end
            T2: begin
                bus.select = reg_sel(ry);
                bus.gin    = 1'b1;
                bus.addsub = (opcode == OP_SUB);
            end
            T3: begin
                bus.select = SEL_G;
                bus.rin    = 8'd1 << rx;
                bus.done   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_proc_control_unit.sv
// Bench for proc_control_unit: directed and random instructions checked cycle by cycle
// against an instruction-level model of the expected control strobes.
module tb_proc_control_unit;

    localparam logic [9:0] IDLE = 10'b00_0000_0000;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    proc_control_unit_if bus ();

    proc_control_unit #(.IDLE_SELECT(IDLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {select, rin, ain, gin, addsub, done}
    function automatic logic [21:0] outs();
        return {bus.select, bus.rin, bus.ain, bus.gin, bus.addsub, bus.done};
    endfunction

    function automatic logic [21:0] pack(input logic [9:0] s, input logic [7:0] r,
                                         input logic a, input logic g, input logic as, input logic d);
        return {s, r, a, g, as, d};
    endfunction

    function automatic logic [9:0] rsel(input int i);
        return 10'(1 << (7 - i));
    endfunction

    // Run one instruction from its fetch cycle to done, checking every cycle.
    task automatic exec_instr(input logic [8:0] instr, input bit hold_run, input bit gnz_v, input string tag);
        logic [21:0] exp_q[$];
        logic [21:0] exp_v;
        int op, x, y, n;
        op = int'(instr[8:6]);
        x  = int'(instr[5:3]);
        y  = int'(instr[2:0]);
        case (op)
            0: exp_q.push_back(pack(rsel(y), 8'(1 << x), 0, 0, 0, 1));
            1: exp_q.push_back(pack(10'(1 << 9), 8'(1 << x), 0, 0, 0, 1));
            2, 3: begin
                exp_q.push_back(pack(rsel(x), 8'd0, 1, 0, 0, 0));
                exp_q.push_back(pack(rsel(y), 8'd0, 0, 1, (op == 3), 0));
                exp_q.push_back(pack(10'(1 << 8), 8'(1 << x), 0, 0, 0, 1));
            end
`ifdef CTRL_MVNZ_EN
            4: exp_q.push_back(pack(rsel(y), gnz_v ? 8'(1 << x) : 8'd0, 0, 0, 0, 1));
`endif
            default: exp_q.push_back(pack(IDLE, 8'd0, 0, 0, 0, 1));
        endcase
        n = exp_q.size();

        @(negedge clk);
        bus.run = 1'b1;
        bus.din = 16'($urandom);
        bus.din[8:0] = instr;
`ifdef CTRL_MVNZ_EN
        bus.gnz = gnz_v;
`endif
        checks++;
        if (bus.step !== 2'd0 || outs() !== pack(IDLE, 8'd0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL %s t0_idle: step=%0d outs=%h required step=0 outs=%h", tag, bus.step, outs(), pack(IDLE, 8'd0, 0, 0, 0, 0));
        end
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            bus.run = hold_run ? 1'b1 : 1'($urandom);
            bus.din = 16'($urandom);
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.step !== 2'(k)) begin
                errors++;
                $display("FAIL %s step_t%0d: got %0d required %0d", tag, k, bus.step, k);
            end
            checks++;
            if (bus.ir !== instr) begin
                errors++;
                $display("FAIL %s ir_t%0d: got %b required %b", tag, k, bus.ir, instr);
            end
            checks++;
            if (outs() !== exp_v) begin
                errors++;
                $display("FAIL %s outs_t%0d: got %h required %h", tag, k, outs(), exp_v);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.step !== 2'd0 || bus.ir !== 9'd0 || outs() !== pack(IDLE, 8'd0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_state: step=%0d ir=%b outs=%h required 0/0/%h", bus.step, bus.ir, outs(), pack(IDLE, 8'd0, 0, 0, 0, 0));
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mvi();
        exec_instr(9'b001_010_000, 1'b0, 1'b0, "mvi_r2");
    endtask

    task automatic test_mv();
        exec_instr(9'b000_101_001, 1'b0, 1'b0, "mv_r5_r1");
        exec_instr(9'b000_011_011, 1'b0, 1'b0, "mv_r3_r3");
    endtask

    task automatic test_sub();
        exec_instr(9'b011_000_111, 1'b0, 1'b0, "sub_r0_r7");
        exec_instr(9'b010_010_010, 1'b0, 1'b0, "add_r2_r2");
    endtask

    task automatic test_back_to_back();
        exec_instr(9'b010_001_110, 1'b1, 1'b0, "b2b_add0");
        exec_instr(9'b010_110_001, 1'b1, 1'b0, "b2b_add1");
        exec_instr(9'b000_111_000, 1'b1, 1'b0, "b2b_mv");
    endtask

    task automatic test_nop();
        exec_instr(9'b101_011_010, 1'b0, 1'b0, "nop_101");
        exec_instr(9'b111_111_111, 1'b0, 1'b0, "nop_111");
    endtask

    task automatic test_mvnz();
        exec_instr(9'b100_100_001, 1'b0, 1'b0, "op100_gnz0");
        exec_instr(9'b100_100_001, 1'b0, 1'b1, "op100_gnz1");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.run = 1'b1;
        bus.din = 16'h0000;
        bus.din[8:0] = 9'b010_100_011;
        @(negedge clk);
        bus.run = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.step !== 2'd2 || bus.gin !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: step=%0d gin=%b required step=2 gin=1", bus.step, bus.gin);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.step !== 2'd0 || bus.ir !== 9'd0 || outs() !== pack(IDLE, 8'd0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL rst_mid_async: step=%0d ir=%b outs=%h required 0/0/%h", bus.step, bus.ir, outs(), pack(IDLE, 8'd0, 0, 0, 0, 0));
        end
        @(negedge clk);
        checks++;
        if (bus.step !== 2'd0 || bus.rin !== 8'd0 || bus.done !== 1'b0 || bus.gin !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_next: step=%0d rin=%b done=%b gin=%b required 0/0/0/0", bus.step, bus.rin, bus.done, bus.gin);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            exec_instr(9'($urandom), 1'($urandom), 1'($urandom), "rand");
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        bus.run = 1'b0;
        bus.din = 16'h0000;
`ifdef CTRL_MVNZ_EN
        bus.gnz = 1'b0;
`endif
        test_reset();
        test_mvi();
        test_mv();
        test_sub();
        test_back_to_back();
        test_nop();
        test_mvnz();
        test_reset_mid();
        test_random();
        @(negedge clk);
        bus.run = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
